// File: rtl/gppcu_pkg.sv
// GPPCU thread register file: shared defaults and sizing helper.
// Holds the default lane geometry and a constant clog2 function.
package gppcu_pkg;

    localparam int GPPCU_DBW   = 32;
    localparam int GPPCU_NREG  = 16;
    localparam int GPPCU_LANES = 4;

    // Constant-evaluable ceil(log2(n)), minimum 1 bit.
    function automatic int gppcu_clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gppcu_regfile_lane.sv
// GPPCU register file, one SIMD lane: storage, write-through bypass,
// registered read ports A/B. Ports: iACLK/iRESET, iRDEN + A/B selects,
// iWE/iREGDSEL/iREGD write, oREGA/oREGB registered read data.
module gppcu_regfile_lane
    import gppcu_pkg::*;
#(
    parameter int DBW     = GPPCU_DBW,
    parameter int NREG    = GPPCU_NREG,
    parameter int ZERO_R0 = 1,
    parameter int RSW     = gppcu_clog2(NREG)
) (
    input  logic           iACLK,
    input  logic           iRESET,
    input  logic           iRDEN,
    input  logic [RSW-1:0] iREGASEL,
    input  logic [RSW-1:0] iREGBSEL,
    input  logic           iWE,
    input  logic [RSW-1:0] iREGDSEL,
    input  logic [DBW-1:0] iREGD,
    output logic [DBW-1:0] oREGA,
    output logic [DBW-1:0] oREGB
);

    localparam bit Z0 = (ZERO_R0 != 0);

    logic [DBW-1:0] mem_q [NREG];
    logic [DBW-1:0] rega_q, regb_q;
    logic [DBW-1:0] rega_d, regb_d;
    logic           wr_ok;

    // Bypass the in-flight write; R0 forced to zero takes priority.
    always_comb begin
        wr_ok  = iWE && !(Z0 && (iREGDSEL == '0));
        rega_d = mem_q[iREGASEL];
        regb_d = mem_q[iREGBSEL];
        if (wr_ok && (iREGDSEL == iREGASEL)) rega_d = iREGD;
        if (wr_ok && (iREGDSEL == iREGBSEL)) regb_d = iREGD;
        if (Z0 && (iREGASEL == '0)) rega_d = '0;
        if (Z0 && (iREGBSEL == '0)) regb_d = '0;
    end

    always_ff @(posedge iACLK) begin
        if (iRESET) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
            rega_q <= '0;
            regb_q <= '0;
        end else begin
            if (wr_ok) mem_q[iREGDSEL] <= iREGD;
            if (iRDEN) begin
                rega_q <= rega_d;
                regb_q <= regb_d;
            end
        end
    end

    assign oREGA = rega_q;
    assign oREGB = regb_q;

endmodule

// File: rtl/gppcu_thread_regfile_sb.sv
// GPPCU SIMD thread register file with multi-cycle-op scoreboard.
// Ports: iACLK/iRESET; read iRDEN/iREGASEL/iREGBSEL -> oREGA/oREGB;
// write iWR/iREGDSEL/iREGD/iLANEMASK; issue iISSUE/iISSUESEL;
// oBUSY hazard stall (combinational), oPENDING scoreboard (registered).
module gppcu_thread_regfile_sb
    import gppcu_pkg::*;
#(
    parameter int DBW     = GPPCU_DBW,
    parameter int NREG    = GPPCU_NREG,
    parameter int LANES   = GPPCU_LANES,
    parameter int ZERO_R0 = 1,
    localparam int RSW    = gppcu_clog2(NREG)
) (
    input  logic                 iACLK,
    input  logic                 iRESET,
    input  logic [RSW-1:0]       iREGASEL,
    input  logic [RSW-1:0]       iREGBSEL,
    input  logic                 iRDEN,
    output logic [LANES*DBW-1:0] oREGA,
    output logic [LANES*DBW-1:0] oREGB,
    input  logic                 iWR,
    input  logic [RSW-1:0]       iREGDSEL,
    input  logic [LANES*DBW-1:0] iREGD,
    input  logic [LANES-1:0]     iLANEMASK,
    input  logic                 iISSUE,
    input  logic [RSW-1:0]       iISSUESEL,
    output logic                 oBUSY,
    output logic [NREG-1:0]      oPENDING
);

    localparam bit Z0 = (ZERO_R0 != 0);

    logic [NREG-1:0] pend_q, pend_d;
    logic [NREG-1:0] wr_oh, iss_oh, effpend;
    logic            busy, iss_ok, rd_go;

    // A write in flight retires its pending bit in the same cycle,
    // so a reader waiting on it is released without a bubble.
    always_comb begin
        wr_oh  = '0;
        iss_oh = '0;
        if (iWR) wr_oh[iREGDSEL] = 1'b1;
        iss_oh[iISSUESEL] = 1'b1;
        effpend = pend_q & ~wr_oh;
        busy    = (iRDEN && (effpend[iREGASEL] || effpend[iREGBSEL]))
                || (iISSUE && effpend[iISSUESEL]);
        iss_ok  = iISSUE && !busy && !(Z0 && (iISSUESEL == '0));
        // Set applied after clear: issue beats same-cycle write-back.
        pend_d  = effpend | (iss_ok ? iss_oh : '0);
        rd_go   = iRDEN && !busy;
    end

    always_ff @(posedge iACLK) begin
        if (iRESET) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign oBUSY    = busy;
    assign oPENDING = pend_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gppcu_regfile_lane #(
            .DBW     (DBW),
            .NREG    (NREG),
            .ZERO_R0 (ZERO_R0),
            .RSW     (RSW)
        ) u_lane (
            .iACLK    (iACLK),
            .iRESET   (iRESET),
            .iRDEN    (rd_go),
            .iREGASEL (iREGASEL),
            .iREGBSEL (iREGBSEL),
            .iWE      (iWR && iLANEMASK[k]),
            .iREGDSEL (iREGDSEL),
            .iREGD    (iREGD[k*DBW +: DBW]),
            .oREGA    (oREGA[k*DBW +: DBW]),
            .oREGB    (oREGB[k*DBW +: DBW])
        );
    end

endmodule
